// File: rtl/minesweeper_pkg.sv
// Shared constants for the minesweeper board logic: cell and cover encodings,
// flood-fill state encoding and the neighbour offset table.
package minesweeper_pkg;

  localparam logic [4:0]  CELL_MINE      = 5'b11111;
  localparam logic [1:0]  COVER_HIDDEN   = 2'b00;
  localparam logic [1:0]  COVER_OPEN     = 2'b01;
  localparam int unsigned COVER_FLAG_BIT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StEval,
    StNbr,
    StFinish
  } flood_state_e;

  // 2-bit two's-complement offsets, visited in raster order around the cell
  localparam logic [1:0] NBR_DX [8] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};
  localparam logic [1:0] NBR_DY [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

endpackage

// File: rtl/coord_stack.sv
// Synchronous LIFO of packed coordinates with push, pop, clear and empty.
module coord_stack #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp_q;
  logic [PW-1:0]    sp_m1;

  assign sp_m1 = sp_q - PW'(1);
  assign top   = mem[sp_m1[AW-1:0]];
  assign empty = (sp_q == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sp_q <= '0;
    end else if (push) begin
      mem[sp_q[AW-1:0]] <= push_data;
      sp_q              <= sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_m1;
    end
  end

endmodule

// File: rtl/flood_opener.sv
// Open-cell responder: opens the requested cell and, when it is a zero, flood-fills
// the connected zero region plus its numbered border through a coordinate stack.
module flood_opener
  import minesweeper_pkg::*;
#(
  parameter int unsigned X_SIZE = 16,
  parameter int unsigned Y_SIZE = 16,
  parameter int unsigned X_BITS = 4,
  parameter int unsigned Y_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              open_req,
  input  logic [X_BITS-1:0] req_x,
  input  logic [Y_BITS-1:0] req_y,
  output logic [X_BITS-1:0] rd_x,
  output logic [Y_BITS-1:0] rd_y,
  input  logic [4:0]        board_val,
  input  logic [1:0]        cover_val,
  output logic              cov_we,
  output logic [X_BITS-1:0] cov_x,
  output logic [Y_BITS-1:0] cov_y,
  output logic [1:0]        cov_wdata,
  output logic              opened_cell,
  output logic              hit_mine,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CELLS = X_SIZE * Y_SIZE;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned CW    = X_BITS + Y_BITS;

  flood_state_e     state_q;
  logic [2:0]       k_q;
  logic [CELLS-1:0] queued_q;

  logic             stk_push, stk_pop, stk_clear, stk_empty;
  logic [CW-1:0]    stk_wdata, stk_top;

  logic [1:0]       dx, dy;
  logic [X_BITS:0]  nx;
  logic [Y_BITS:0]  ny;
  logic [IDX_W-1:0] nbr_idx, req_idx;
  logic             nbr_ok, cell_hidden, cell_mine, cell_zero, eval_cont, nbr_last;

  always_comb begin
    dx = NBR_DX[k_q];
    dy = NBR_DY[k_q];
    // One extra bit: -1 lands far above the board size instead of wrapping onto it
    nx = {1'b0, rd_x} + {{(X_BITS-1){dx[1]}}, dx};
    ny = {1'b0, rd_y} + {{(Y_BITS-1){dy[1]}}, dy};
    nbr_idx = IDX_W'(32'(ny[Y_BITS-1:0]) * X_SIZE + 32'(nx[X_BITS-1:0]));
    req_idx = IDX_W'(32'(req_y) * X_SIZE + 32'(req_x));
    nbr_ok = (state_q == StNbr) && (nx < (X_BITS+1)'(X_SIZE)) &&
             (ny < (Y_BITS+1)'(Y_SIZE)) && !queued_q[nbr_idx];

    cell_hidden = !cover_val[COVER_FLAG_BIT] && (cover_val != COVER_OPEN);
    cell_mine   = (board_val == CELL_MINE);
    cell_zero   = (board_val == '0);
    eval_cont   = (state_q == StEval) && !(cell_hidden && (cell_mine || cell_zero));
    nbr_last    = (state_q == StNbr) && (k_q == 3'd7);

    // A neighbour found on the last slot goes straight to rd instead of via the stack
    stk_push  = nbr_ok && !nbr_last;
    stk_pop   = !stk_empty && (eval_cont || (nbr_last && !nbr_ok));
    stk_clear = (state_q == StEval) && cell_hidden && cell_mine;
    stk_wdata = {ny[Y_BITS-1:0], nx[X_BITS-1:0]};
  end

  coord_stack #(
    .DEPTH(CELLS),
    .WIDTH(CW)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (stk_clear),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(stk_wdata),
    .top      (stk_top),
    .empty    (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      queued_q    <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      cov_x       <= '0;
      cov_y       <= '0;
      cov_wdata   <= COVER_OPEN;
      cov_we      <= 1'b0;
      opened_cell <= 1'b0;
      hit_mine    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cov_we      <= 1'b0;
      opened_cell <= 1'b0;
      hit_mine    <= 1'b0;
      done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (open_req) begin
            queued_q          <= '0;
            queued_q[req_idx] <= 1'b1;
            rd_x              <= req_x;
            rd_y              <= req_y;
            busy              <= 1'b1;
            state_q           <= StRead;
          end
        end
        StRead: state_q <= StEval;
        StEval: begin
          if (cell_hidden) begin
            cov_we <= 1'b1;
            cov_x  <= rd_x;
            cov_y  <= rd_y;
            if (cell_mine) hit_mine <= 1'b1;
            else           opened_cell <= 1'b1;
          end
          if (cell_hidden && cell_mine) begin
            state_q <= StFinish;
          end else if (cell_hidden && cell_zero) begin
            k_q     <= '0;
            state_q <= StNbr;
          end else if (!stk_empty) begin
            {rd_y, rd_x} <= stk_top;
            state_q      <= StRead;
          end else begin
            state_q <= StFinish;
          end
        end
        StNbr: begin
          if (nbr_ok) queued_q[nbr_idx] <= 1'b1;
          k_q <= k_q + 3'd1;
          if (nbr_last) begin
            if (nbr_ok) begin
              {rd_y, rd_x} <= stk_wdata;
              state_q      <= StRead;
            end else if (!stk_empty) begin
              {rd_y, rd_x} <= stk_top;
              state_q      <= StRead;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StFinish: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_opener.sv
// Bench for flood_opener: board/cover memories with 1-cycle reads, a queue-based
// region model, cycle-exact directed cases and randomized boards.
module tb_flood_opener;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       open_req = 1'b0;
  logic [3:0] req_x = '0, req_y = '0;
  logic [3:0] rd_x, rd_y, cov_x, cov_y;
  logic [4:0] board_val;
  logic [1:0] cover_val, cov_wdata;
  logic       cov_we, opened_cell, hit_mine, busy, done;

  flood_opener #(
    .X_SIZE(16),
    .Y_SIZE(16),
    .X_BITS(4),
    .Y_BITS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .open_req   (open_req),
    .req_x      (req_x),
    .req_y      (req_y),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .board_val  (board_val),
    .cover_val  (cover_val),
    .cov_we     (cov_we),
    .cov_x      (cov_x),
    .cov_y      (cov_y),
    .cov_wdata  (cov_wdata),
    .opened_cell(opened_cell),
    .hit_mine   (hit_mine),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [4:0] board_mem  [N];
  logic [1:0] cov_init   [N];
  int         written_gen[N];
  int         cur_gen = 1;
  bit         exp_w      [N];
  int         vec = 0, errs = 0;

  // Cover reads see writes from the current test generation only
  always @(posedge clk) begin
    board_val <= board_mem[{rd_y, rd_x}];
    cover_val <= (written_gen[{rd_y, rd_x}] == cur_gen) ? 2'b01 : cov_init[{rd_y, rd_x}];
    if (cov_we) written_gen[{cov_y, cov_x}] <= cur_gen;
  end

  int m_open, m_hit, m_w;
  int r_open, r_we, r_hit, r_done, r_bad, r_dup, r_busy_drop, r_cycles, r_done_at;

  task automatic fill_board(input logic [4:0] v);
    for (int i = 0; i < N; i++) board_mem[i] = v;
  endtask

  task automatic fill_cover(input logic [1:0] v);
    for (int i = 0; i < N; i++) cov_init[i] = v;
  endtask

  task automatic model_open(input int tx, input int ty);
    int q[$];
    bit seen[N];
    int c, cx, cy, ax, ay;
    m_open = 0; m_hit = 0; m_w = 0;
    for (int i = 0; i < N; i++) begin exp_w[i] = 0; seen[i] = 0; end
    seen[ty * 16 + tx] = 1;
    q.push_back(ty * 16 + tx);
    while (q.size() > 0) begin
      c = q.pop_front();
      if (cov_init[c] == 2'b00) begin
        exp_w[c] = 1; m_w++;
        if (board_mem[c] == 5'd31) begin
          m_hit = 1;
          q.delete();
        end else begin
          m_open++;
          if (board_mem[c] == 5'd0) begin
            cx = c % 16; cy = c / 16;
            for (int oy = -1; oy <= 1; oy++) begin
              for (int ox = -1; ox <= 1; ox++) begin
                ax = cx + ox; ay = cy + oy;
                if ((ox != 0 || oy != 0) && ax >= 0 && ax < 16 && ay >= 0 && ay < 16 &&
                    !seen[ay * 16 + ax]) begin
                  seen[ay * 16 + ax] = 1;
                  q.push_back(ay * 16 + ax);
                end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic clear_r;
    r_open = 0; r_we = 0; r_hit = 0; r_done = 0; r_bad = 0; r_dup = 0;
    r_busy_drop = 0; r_cycles = 0; r_done_at = -1;
  endtask

  task automatic sample_outputs;
    if (cov_we) begin
      r_we++;
      if (!exp_w[{cov_y, cov_x}]) r_bad++;
      if (written_gen[{cov_y, cov_x}] == cur_gen) r_dup++;
    end
    if (opened_cell) r_open++;
    if (hit_mine) r_hit++;
    if (done) begin
      r_done++;
      if (r_done_at < 0) r_done_at = r_cycles;
    end else if (!busy && r_done == 0) begin
      r_busy_drop++;
    end
  endtask

  // Issue a request at the current negedge; sample until done (bounded) plus a short tail
  task automatic run_open(input int tx, input int ty, input int budget);
    clear_r();
    req_x = tx[3:0]; req_y = ty[3:0]; open_req = 1'b1;
    @(negedge clk);
    open_req = 1'b0;
    while (r_done == 0 && r_cycles < budget) begin
      r_cycles++;
      sample_outputs();
      @(negedge clk);
    end
    repeat (4) begin
      sample_outputs();
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({rd_y, rd_x, cov_y, cov_x} !== 16'h0000) begin
      errs++; $display("FAIL reset_addr: got %h expected 0000", {rd_y, rd_x, cov_y, cov_x});
    end
    vec++;
    if (cov_wdata !== 2'b01) begin
      errs++; $display("FAIL reset_wdata: got %b expected 01", cov_wdata);
    end
    vec++;
    if ({cov_we, opened_cell, hit_mine, busy, done} !== 5'b00000) begin
      errs++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {cov_we, opened_cell, hit_mine, busy, done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_isolated;
    cur_gen++; fill_board(5'd1); fill_cover(2'b00);
    board_mem[5 * 16 + 3] = 5'd2;
    req_x = 4'd3; req_y = 4'd5; open_req = 1'b1;
    @(negedge clk);
    open_req = 1'b0;
    vec++;
    if ({busy, rd_y, rd_x} !== {1'b1, 4'd5, 4'd3}) begin
      errs++; $display("FAIL iso_c1_rd: got %h expected 153", {busy, rd_y, rd_x});
    end
    repeat (2) @(negedge clk);
    vec++;
    if ({opened_cell, cov_we, hit_mine} !== 3'b110) begin
      errs++; $display("FAIL iso_c3_strobes: got %b expected 110", {opened_cell, cov_we, hit_mine});
    end
    vec++;
    if ({cov_y, cov_x, cov_wdata} !== {4'd5, 4'd3, 2'b01}) begin
      errs++; $display("FAIL iso_c3_wr: got %h expected 14d", {cov_y, cov_x, cov_wdata});
    end
    @(negedge clk);
    vec++;
    if ({done, busy} !== 2'b10) begin
      errs++; $display("FAIL iso_c4_done: got %b expected 10", {done, busy});
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0) begin
      errs++; $display("FAIL iso_c5_done: got %b expected 0", done);
    end
  endtask

  task automatic test_mine;
    cur_gen++; fill_board(5'd1); fill_cover(2'b00);
    board_mem[0] = 5'd31;
    model_open(0, 0);
    req_x = 4'd0; req_y = 4'd0; open_req = 1'b1;
    @(negedge clk);
    open_req = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({opened_cell, cov_we, hit_mine} !== 3'b011) begin
      errs++; $display("FAIL mine_c3: got %b expected 011", {opened_cell, cov_we, hit_mine});
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b1) begin
      errs++; $display("FAIL mine_c4_done: got %b expected 1", done);
    end
    clear_r();
    repeat (8) begin @(negedge clk); sample_outputs(); end
    vec++;
    if (r_we !== 0) begin
      errs++; $display("FAIL mine_late_writes: got %0d expected 0", r_we);
    end
  endtask

  task automatic test_all_zero;
    cur_gen++; fill_board(5'd0); fill_cover(2'b00);
    model_open(7, 7);
    run_open(7, 7, 4000);
    vec++;
    if (r_open !== 256) begin
      errs++; $display("FAIL zero_opened: got %0d expected 256", r_open);
    end
    vec++;
    if (r_we !== 256 || r_dup !== 0) begin
      errs++; $display("FAIL zero_writes: got %0d (dup %0d) expected 256 (dup 0)", r_we, r_dup);
    end
    vec++;
    if (r_done !== 1 || r_busy_drop !== 0) begin
      errs++;
      $display("FAIL zero_done_busy: got done=%0d busy_drop=%0d expected 1/0", r_done, r_busy_drop);
    end
  endtask

  task automatic test_corner;
    cur_gen++; fill_board(5'd31); fill_cover(2'b00);
    board_mem[15 * 16 + 15] = 5'd0;
    board_mem[14 * 16 + 14] = 5'd1;
    board_mem[14 * 16 + 15] = 5'd1;
    board_mem[15 * 16 + 14] = 5'd1;
    model_open(15, 15);
    run_open(15, 15, 400);
    vec++;
    if (r_open !== 4 || r_hit !== 0) begin
      errs++; $display("FAIL corner: got open=%0d hit=%0d expected 4/0", r_open, r_hit);
    end
    vec++;
    if (r_bad !== 0 || r_done !== 1) begin
      errs++; $display("FAIL corner_wr: got bad=%0d done=%0d expected 0/1", r_bad, r_done);
    end
  endtask

  task automatic test_flagged;
    cur_gen++; fill_board(5'd0); fill_cover(2'b00);
    cov_init[4 * 16 + 4] = 2'b10;
    model_open(4, 4);
    clear_r();
    req_x = 4'd4; req_y = 4'd4; open_req = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      r_cycles = cyc;
      sample_outputs();
      open_req = (cyc == 1);
      @(negedge clk);
    end
    open_req = 1'b0;
    vec++;
    if (r_we !== 0 || r_open !== 0) begin
      errs++; $display("FAIL flag_nowrite: got we=%0d open=%0d expected 0/0", r_we, r_open);
    end
    vec++;
    if (r_done !== 1 || r_done_at !== 4) begin
      errs++;
      $display("FAIL flag_done: got count=%0d cycle=%0d expected 1/4", r_done, r_done_at);
    end
  endtask

  task automatic test_reset_mid;
    cur_gen++; fill_board(5'd0); fill_cover(2'b00);
    model_open(2, 9);
    clear_r();
    req_x = 4'd2; req_y = 4'd9; open_req = 1'b1;
    @(negedge clk);
    open_req = 1'b0;
    while (r_open < 5 && r_cycles < 300) begin
      r_cycles++;
      sample_outputs();
      if (r_open < 5) @(negedge clk);
    end
    vec++;
    if (r_open !== 5) begin
      errs++; $display("FAIL rst_mid_reach5: got %0d expected 5", r_open);
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_mid_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    clear_r();
    r_done_at = 0;
    repeat (20) begin sample_outputs(); @(negedge clk); end
    vec++;
    if (r_we !== 0 || r_done !== 0) begin
      errs++; $display("FAIL rst_mid_quiet: got we=%0d done=%0d expected 0/0", r_we, r_done);
    end
    cur_gen++;
    model_open(12, 3);
    run_open(12, 3, 4000);
    vec++;
    if (r_open !== 256 || r_done !== 1) begin
      errs++; $display("FAIL rst_mid_reopen: got open=%0d done=%0d expected 256/1", r_open, r_done);
    end
  endtask

  task automatic test_random;
    bit mine[N];
    int cnt, tx, ty, rv, ax, ay;
    for (int it = 0; it < 20; it++) begin
      cur_gen++;
      for (int i = 0; i < N; i++) mine[i] = ($urandom_range(99) < 12);
      for (int i = 0; i < N; i++) begin
        cnt = 0;
        for (int oy = -1; oy <= 1; oy++) begin
          for (int ox = -1; ox <= 1; ox++) begin
            ax = i % 16 + ox; ay = i / 16 + oy;
            if ((ox != 0 || oy != 0) && ax >= 0 && ax < 16 && ay >= 0 && ay < 16 &&
                mine[ay * 16 + ax]) cnt++;
          end
        end
        board_mem[i] = mine[i] ? 5'd31 : 5'(cnt);
        rv = $urandom_range(99);
        cov_init[i] = (rv < 4) ? 2'b10 : (rv < 8) ? 2'b11 : (rv < 12) ? 2'b01 : 2'b00;
      end
      tx = $urandom_range(15); ty = $urandom_range(15);
      model_open(tx, ty);
      run_open(tx, ty, 4000);
      vec++;
      if (r_open !== m_open || r_hit !== m_hit) begin
        errs++;
        $display("FAIL rand_open[%0d]: got open=%0d hit=%0d expected %0d/%0d",
                 it, r_open, r_hit, m_open, m_hit);
      end
      vec++;
      if (r_we !== m_w || r_bad !== 0 || r_dup !== 0) begin
        errs++;
        $display("FAIL rand_writes[%0d]: got we=%0d bad=%0d dup=%0d expected %0d/0/0",
                 it, r_we, r_bad, r_dup, m_w);
      end
      vec++;
      if (r_done !== 1 || r_busy_drop !== 0) begin
        errs++;
        $display("FAIL rand_done[%0d]: got done=%0d busy_drop=%0d expected 1/0",
                 it, r_done, r_busy_drop);
      end
    end
  endtask

  initial begin
    fill_board(5'd0);
    fill_cover(2'b00);
    test_reset();
    test_isolated();
    test_mine();
    test_all_zero();
    test_corner();
    test_flagged();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
